// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL lock sequencer: state encoding, output bundle, default timing constants.
// Pure declarations: no latency, no flow control.
package pll_seq_pkg;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 120000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1200;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_CNT_WIDTH           = 20;
  localparam int LOCK_LOSS_CNT_WIDTH     = 8;

  typedef enum logic [2:0] {
    ST_ASSERT_RST = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABILIZE  = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAIL       = 3'd4
  } state_e;

  typedef struct packed {
    logic pll_rst;
    logic sys_reset_n;
    logic locked;
    logic fail;
  } ctl_t;

  // Output levels that hold for the whole time the FSM sits in a state.
  function automatic ctl_t state_ctl(input state_e s);
    ctl_t c;
    c.pll_rst     = (s == ST_ASSERT_RST) || (s == ST_FAIL);
    c.sys_reset_n = (s == ST_RUN);
    c.locked      = (s == ST_RUN);
    c.fail        = (s == ST_FAIL);
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for slow level signals crossing into clk.
// Latency: 2 clk cycles; no flow control, level in / level out.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL supervisor on the reference clock: pulses PLL reset, waits for and qualifies LOCK, releases system reset, bounded retries.
// Outputs registered, updated on the deciding edge (pll_lock adds 2 sync cycles); no backpressure, soft_restart overrides every transition.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int  RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int  LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int  LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int  MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int  CNT_WIDTH           = DEF_CNT_WIDTH,
  localparam int RETRY_W             = $clog2(MAX_RETRIES + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           soft_restart,
  input  logic                           pll_lock,
  output logic                           pll_rst,
  output logic                           sys_reset_n,
  output logic                           locked,
  output logic                           fail,
  output logic [RETRY_W-1:0]             retry_count,
  output logic [LOCK_LOSS_CNT_WIDTH-1:0] lock_loss_count,
  output logic [2:0]                     state_dbg
);

  localparam logic [CNT_WIDTH-1:0] PULSE_LAST   = CNT_WIDTH'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [RETRY_W-1:0]   LAST_TRY     = RETRY_W'(MAX_RETRIES - 1);
  localparam logic [RETRY_W-1:0]   RETRY_ONE    = RETRY_W'(1);
  localparam logic [LOCK_LOSS_CNT_WIDTH-1:0] LOSS_ONE = LOCK_LOSS_CNT_WIDTH'(1);

  state_e                         state;
  logic [CNT_WIDTH-1:0]           cnt;
  ctl_t                           ctl;
  logic                           lock_s;
  state_e                         retry_dest;
  logic [LOCK_LOSS_CNT_WIDTH-1:0] loss_next;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Where a failed attempt lands: another reset pulse, or FAIL once the budget is spent.
  assign retry_dest = (retry_count == LAST_TRY) ? ST_FAIL : ST_ASSERT_RST;
  assign loss_next  = (lock_loss_count == '1) ? lock_loss_count : lock_loss_count + LOSS_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_ASSERT_RST;
      cnt             <= '0;
      ctl             <= state_ctl(ST_ASSERT_RST);
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else if (soft_restart) begin
      state       <= ST_ASSERT_RST;
      cnt         <= '0;
      ctl         <= state_ctl(ST_ASSERT_RST);
      retry_count <= '0;
    end else begin
      case (state)
        ST_ASSERT_RST: begin
          if (cnt == PULSE_LAST) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
            ctl   <= state_ctl(ST_WAIT_LOCK);
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state <= ST_STABILIZE;
            cnt   <= '0;
            ctl   <= state_ctl(ST_STABILIZE);
          end else if (cnt == TIMEOUT_LAST) begin
            state       <= retry_dest;
            cnt         <= '0;
            ctl         <= state_ctl(retry_dest);
            retry_count <= retry_count + RETRY_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_STABILIZE: begin
          if (!lock_s) begin
            state       <= retry_dest;
            cnt         <= '0;
            ctl         <= state_ctl(retry_dest);
            retry_count <= retry_count + RETRY_ONE;
          end else if (cnt == STABLE_LAST) begin
            state       <= ST_RUN;
            cnt         <= '0;
            ctl         <= state_ctl(ST_RUN);
            retry_count <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state           <= ST_ASSERT_RST;
            cnt             <= '0;
            ctl             <= state_ctl(ST_ASSERT_RST);
            lock_loss_count <= loss_next;
          end
        end
        ST_FAIL: begin
        end
        default: begin
          state <= ST_ASSERT_RST;
          cnt   <= '0;
          ctl   <= state_ctl(ST_ASSERT_RST);
        end
      endcase
    end
  end

  assign pll_rst     = ctl.pll_rst;
  assign sys_reset_n = ctl.sys_reset_n;
  assign locked      = ctl.locked;
  assign fail        = ctl.fail;
  assign state_dbg   = state;

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Supervises the on-chip PLL (12 MHz reference in, 36 MHz CLKOP out, active-high RST in, LOCK out). It runs on the reference clock, pulses the PLL reset, and waits for LOCK with a timeout. It then qualifies LOCK for a stable window before releasing the system reset, and retries a bounded number of times before declaring failure. It sits between the board clock/reset pins and the PLL/system reset tree. CDC of its outputs into the CLKOP domain is handled outside this block.

Parameters:
RST_PULSE_CYCLES, 16, PLL RST high time per attempt in clk cycles (>=1)
LOCK_TIMEOUT_CYCLES, 120000, max cycles in WAIT_LOCK per attempt (10 ms @12 MHz)
LOCK_STABLE_CYCLES, 1200, consecutive synced-LOCK-high cycles required before release (100 us)
MAX_RETRIES, 3, failed attempts tolerated before FAIL (>=1)
CNT_WIDTH, 20, width of the shared cycle counter; must hold max(all three cycle params)

Ports:
clk  in  1  reference clock (same net as PLL CLKI)
reset_n  in  1  asynchronous active-low reset
soft_restart  in  1  single-cycle pulse: restart sequence from any state
pll_lock  in  1  PLL LOCK, asynchronous to clk
pll_rst  out  1  to PLL RST, active high
sys_reset_n  out  1  system reset request, active low
locked  out  1  high only in RUN
fail  out  1  high only in FAIL
retry_count  out  $clog2(MAX_RETRIES+1)  failed attempts in current sequence
lock_loss_count  out  8  saturating count of LOCK drops while in RUN
state_dbg  out  3  current state encoding

Behaviour:
- All outputs registered. While reset_n low: state=ASSERT_RST, counter=0, pll_rst=1, sys_reset_n=0, locked=0, fail=0, retry_count=0, lock_loss_count=0.
- pll_lock passes through a 2-flop synchronizer (lock_s). 2-cycle latency, reset value 0.
- States and encoding: ASSERT_RST=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAIL=4.
- ASSERT_RST: pll_rst=1. Counter counts 0..RST_PULSE_CYCLES-1, then goes to WAIT_LOCK with counter=0. pll_rst is high for exactly RST_PULSE_CYCLES cycles after reset release.
- WAIT_LOCK: pll_rst=0.
  - If lock_s=1, go to STABILIZE, counter=0.
  - Else if counter==LOCK_TIMEOUT_CYCLES-1, the attempt fails.
  - lock_s checked before timeout in the same cycle.
- STABILIZE:
  - If lock_s=0, the attempt fails.
  - Else if counter==LOCK_STABLE_CYCLES-1, go to RUN.
- Failed attempt: if retry_count==MAX_RETRIES-1, go to FAIL and increment retry_count to MAX_RETRIES. Otherwise increment retry_count and go to ASSERT_RST with counter=0.
- RUN: sys_reset_n=1, locked=1. On entry retry_count clears to 0.
  - If lock_s=0: lock_loss_count += 1 (holds at 255), go to ASSERT_RST. sys_reset_n and locked fall on the cycle of the state change.
- FAIL: pll_rst=1, fail=1, sys_reset_n=0. Leaves only via soft_restart or reset_n.
- sys_reset_n=0 and locked=0 in every state except RUN. fail=0 except in FAIL.
- soft_restart takes priority over every other transition in the same cycle. It goes to ASSERT_RST with counter=0 and retry_count=0. lock_loss_count is kept. In ASSERT_RST, soft_restart restarts the pulse.
- Counter clears on every state change and never wraps within a state.
- The async reset may assert in any state and returns immediately to the reset values.

Decomposition:
- Package pll_seq_pkg: state enum/encoding, default parameter constants, LOCK_LOSS_CNT_WIDTH=8.
- Sub-module sync_2ff (generic 2-flop synchronizer, asynchronous active-low reset, reset value parameter), instantiated for pll_lock.
- The FSM and counter are inline in pll_lock_sequencer.

Test Plan:
Parameters for all scenarios: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, LOCK_STABLE_CYCLES=10, MAX_RETRIES=2.
1. Nominal lock: release reset_n, raise pll_lock 20 cycles later -> pll_rst high 4 cycles, sys_reset_n/locked rise exactly 2+10 cycles after pll_lock rise, retry_count=0.
2. Timeout: hold pll_lock=0 -> pll_rst pulses twice (4 cycles each, 50-cycle gaps), then fail=1, retry_count=2, state_dbg=4, pll_rst stays 1.
3. Glitch in STABILIZE: pll_lock high 5 cycles, low 1 cycle, then high -> retry_count=1, new 4-cycle pll_rst pulse, locked=1 on second attempt, retry_count=0 in RUN.
4. Lock loss in RUN: drop pll_lock for 3 cycles -> sys_reset_n low 2 cycles after drop, lock_loss_count=1, re-lock sequence completes. Repeat 260 times -> lock_loss_count saturates at 255.
5. soft_restart from FAIL and from RUN -> ASSERT_RST next cycle, retry_count=0, lock_loss_count unchanged.
6. reset_n asserted mid-STABILIZE -> outputs take reset values asynchronously, sequence restarts cleanly on release.
